// File: rtl/pwconv_pkg.sv
// Shared state encoding and index-width helpers for the pointwise-conv accumulator sequencer.
package pwconv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int STALL_W = 32;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Index counter 0..MAX that wraps to zero when incremented at MAX; clr has priority over inc.
module wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         at_max
);

    assign at_max = (value == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/pwconv_acc_ctrl.sv
// Loop-nest sequencer (pixel > out channel > input-channel pairs) driving accumulator flush/enable.
// Optional stall counter output under PWCONV_CTRL_PERF_EN.
module pwconv_acc_ctrl
    import pwconv_pkg::*;
#(
    parameter int CIN    = 32,
    parameter int COUT   = 64,
    parameter int NPIX   = 100,
    parameter int BEAT_W = idx_w(CIN / 2),
    parameter int OCH_W  = idx_w(COUT),
    parameter int PIX_W  = idx_w(NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_flush,
    output logic             acc_en,
    output logic [OCH_W-1:0] bias_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCH_W-1:0] out_ch,
    output logic [PIX_W-1:0] out_pix
`ifdef PWCONV_CTRL_PERF_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    state_t state;

    logic [BEAT_W-1:0] beat_cnt;
    logic [OCH_W-1:0]  och;
    logic [PIX_W-1:0]  pix;
    logic beat_last, och_last, pix_last;
    logic beat, accept, start_acc;

    assign start_acc = (state == IDLE) & start;
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign beat      = in_ready & in_valid;
    assign accept    = out_valid & out_ready;

    // The first beat of each output loads bias; the rest add onto it.
    assign acc_flush = beat & (beat_cnt == '0);
    assign acc_en    = beat & (beat_cnt != '0);
    assign done      = accept & och_last & pix_last;

    assign bias_addr = och;
    assign out_ch    = och;
    assign out_pix   = pix;

    wrap_counter #(.MAX(CIN / 2 - 1), .W(BEAT_W)) u_beat (
        .clk    (clk),
        .rst    (rst),
        .inc    (beat),
        .clr    (start_acc),
        .value  (beat_cnt),
        .at_max (beat_last)
    );

    wrap_counter #(.MAX(COUT - 1), .W(OCH_W)) u_och (
        .clk    (clk),
        .rst    (rst),
        .inc    (accept),
        .clr    (start_acc),
        .value  (och),
        .at_max (och_last)
    );

    wrap_counter #(.MAX(NPIX - 1), .W(PIX_W)) u_pix (
        .clk    (clk),
        .rst    (rst),
        .inc    (accept & och_last),
        .clr    (start_acc),
        .value  (pix),
        .at_max (pix_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) state <= ACC;
                ACC:  if (beat && beat_last) state <= HOLD;
                HOLD: if (accept) state <= done ? IDLE : ACC;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWCONV_CTRL_PERF_EN
    logic stall;

    assign stall = ((state == ACC) & ~in_valid) | ((state == HOLD) & ~out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule
